// File: rtl/timer_ctrl_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : timer_ctrl_seq
// Brief    : Bus-master sequencer that programs, services and snapshots a timer.
// Revision : 1.0
// ============================================================================
module timer_ctrl_seq #(
    parameter int CONT_MODE = 1,
    parameter int TICK_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_stop,
    input  logic              snap_req,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WR_PL    = 4'd1;
    localparam logic [3:0] WR_PH    = 4'd2;
    localparam logic [3:0] WR_CTRL  = 4'd3;
    localparam logic [3:0] RUN      = 4'd4;
    localparam logic [3:0] CLR_ST   = 4'd5;
    localparam logic [3:0] SNAP_WR  = 4'd6;
    localparam logic [3:0] SNAP_RL  = 4'd7;
    localparam logic [3:0] SNAP_RH  = 4'd8;
    localparam logic [3:0] SNAP_CAP = 4'd9;
    localparam logic [3:0] STOP_WR  = 4'd10;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PL     = 3'd2;
    localparam logic [2:0] ADDR_PH     = 3'd3;
    localparam logic [2:0] ADDR_SNAPL  = 3'd4;
    localparam logic [2:0] ADDR_SNAPH  = 3'd5;

    localparam logic        CONT_BIT   = (CONT_MODE != 0);
    // START | ITO, plus CONT when the timer should reload itself.
    localparam logic [15:0] CTRL_START = {14'h0001, CONT_BIT, 1'b1};
    localparam logic [15:0] CTRL_STOP  = 16'h0008;
    localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

    logic [3:0]  state;
    logic [3:0]  next_state;
    logic [31:0] period;
    logic [15:0] snap_lo;
    logic [15:0] snap_hi;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (cmd_start) next_state = WR_PL;
            WR_PL:    next_state = WR_PH;
            WR_PH:    next_state = WR_CTRL;
            WR_CTRL:  next_state = RUN;
            RUN: begin
                // A timeout wins; a stop or snapshot in the same cycle is dropped.
                if (tmr_irq)       next_state = CLR_ST;
                else if (cmd_stop) next_state = STOP_WR;
                else if (snap_req) next_state = SNAP_WR;
            end
            CLR_ST:   next_state = CONT_BIT ? RUN : IDLE;
            SNAP_WR:  next_state = SNAP_RL;
            SNAP_RL:  next_state = SNAP_RH;
            SNAP_RH:  next_state = SNAP_CAP;
            SNAP_CAP: next_state = RUN;
            STOP_WR:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            period     <= 32'h0;
            tick_count <= '0;
            snap_lo    <= 16'h0;
            snap_hi    <= 16'h0;
        end else begin
            state <= next_state;
            if (state == IDLE && cmd_start) begin
                period     <= cmd_period;
                tick_count <= '0;
            end
            if (state == CLR_ST) begin
                tick_count <= tick_count + TICK_ONE;
            end
            if (state == SNAP_RH) begin
                snap_lo <= tmr_readdata;
            end
            if (state == SNAP_CAP) begin
                snap_hi <= tmr_readdata;
            end
        end
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0;
        case (state)
            WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_PL;
                tmr_writedata  = period[15:0];
            end
            WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_PH;
                tmr_writedata  = period[31:16];
            end
            WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_CTRL;
                tmr_writedata  = CTRL_START;
            end
            CLR_ST: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_STATUS;
            end
            SNAP_WR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_SNAPL;
            end
            SNAP_RL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = ADDR_SNAPL;
            end
            SNAP_RH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = ADDR_SNAPH;
            end
            STOP_WR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_CTRL;
                tmr_writedata  = CTRL_STOP;
            end
            default: ;
        endcase
    end

    assign busy       = (state != IDLE) && (state != RUN);
    assign running    = (state == RUN) || (state == CLR_ST) || (state == SNAP_WR) ||
                        (state == SNAP_RL) || (state == SNAP_RH) || (state == SNAP_CAP);
    assign tick       = (state == CLR_ST);
    assign snap_valid = (state == SNAP_CAP);
    // The high half arrives in SNAP_CAP itself, so the pulse cycle shows it directly.
    assign snap_value = (state == SNAP_CAP) ? {tmr_readdata, snap_lo} : {snap_hi, snap_lo};

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_timer_ctrl_seq
// Brief    : Self-checking bench for timer_ctrl_seq with a timer slave model.
// Revision : 1.0
// ============================================================================
module tb_timer_ctrl_seq;

    localparam int TICK_W   = 32;
    localparam int OP_START = 0;
    localparam int OP_IRQ   = 1;
    localparam int OP_SNAP  = 2;
    localparam int OP_STOP  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, cmd_start, cmd_stop, snap_req;
    logic [31:0]       cmd_period;
    logic [2:0]        addr;
    logic              cs, wn;
    logic [15:0]       wdata, rdata;
    logic              tmr_irq, busy, running, tick, snap_valid;
    logic [TICK_W-1:0] tick_count;
    logic [31:0]       snap_value;

    logic [2:0]        addr0;
    logic              cs0, wn0, irq0, busy0, running0, tick0, snap_valid0;
    logic [15:0]       wdata0;
    logic [TICK_W-1:0] tick_count0;
    logic [31:0]       snap_value0;

    timer_ctrl_seq #(.CONT_MODE(1), .TICK_W(TICK_W)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_period(cmd_period),
        .cmd_stop(cmd_stop), .snap_req(snap_req), .tmr_address(addr),
        .tmr_chipselect(cs), .tmr_write_n(wn), .tmr_writedata(wdata),
        .tmr_readdata(rdata), .tmr_irq(tmr_irq), .busy(busy), .running(running),
        .tick(tick), .tick_count(tick_count), .snap_value(snap_value),
        .snap_valid(snap_valid)
    );

    timer_ctrl_seq #(.CONT_MODE(0), .TICK_W(TICK_W)) dut0 (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_period(cmd_period),
        .cmd_stop(cmd_stop), .snap_req(snap_req), .tmr_address(addr0),
        .tmr_chipselect(cs0), .tmr_write_n(wn0), .tmr_writedata(wdata0),
        .tmr_readdata(16'h0000), .tmr_irq(irq0), .busy(busy0), .running(running0),
        .tick(tick0), .tick_count(tick_count0), .snap_value(snap_value0),
        .snap_valid(snap_valid0)
    );

    // Timer slave: irq held until a status write, snapshot latched on write to 4.
    logic        irq_fire;
    logic        irq_flag;
    logic [31:0] timer_count;
    logic [31:0] snap_reg;
    assign tmr_irq = irq_flag;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_flag <= 1'b0;
            snap_reg <= 32'h0;
            rdata    <= 16'h0;
        end else begin
            if (irq_fire)                     irq_flag <= 1'b1;
            else if (cs && !wn && addr == 3'd0) irq_flag <= 1'b0;
            if (cs && !wn && addr == 3'd4)    snap_reg <= timer_count;
            if (cs && wn)
                rdata <= (addr == 3'd4) ? snap_reg[15:0] :
                         (addr == 3'd5) ? snap_reg[31:16] : 16'h0;
        end
    end

    logic [19:0] bus_log[$];
    int tick_seen = 0;
    int snap_seen = 0;
    int idle_bad  = 0;

    always @(posedge clk) begin
        if (reset_n) begin
            if (cs) bus_log.push_back({wn, addr, (wn ? 16'h0 : wdata)});
            else if (wn !== 1'b1 || addr !== 3'd0 || wdata !== 16'h0) idle_bad++;
            if (tick) tick_seen++;
            if (snap_valid) snap_seen++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Abstract model: what the controller owes the timer and the user per command.
    logic [19:0] exp_q[$];
    int          log_rd = 0;
    bit          m_run, m_pend;
    logic [31:0] m_ticks, m_snap;
    int          m_tickp = 0;
    int          m_snapp = 0;

    function automatic logic [19:0] bw(input logic [2:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction
    function automatic logic [19:0] br(input logic [2:0] a);
        return {1'b1, a, 16'h0};
    endfunction

    task automatic model_service;
        exp_q.push_back(bw(3'd0, 16'h0000));
        m_ticks = m_ticks + 1;
        m_tickp++;
    endtask

    task automatic flush;
        log_rd = bus_log.size();
        exp_q.delete();
    endtask

    task automatic compare_bus;
        int n;
        n = bus_log.size() - log_rd;
        check("bus_count", n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check("bus_txn", {12'h0, bus_log[log_rd + i]}, {12'h0, exp_q[i]});
        flush();
    endtask

    task automatic do_op(input int op, input logic [31:0] arg);
        case (op)
            OP_START: begin
                if (!m_run) begin
                    exp_q.push_back(bw(3'd2, arg[15:0]));
                    exp_q.push_back(bw(3'd3, arg[31:16]));
                    exp_q.push_back(bw(3'd1, 16'h0007));
                    m_ticks = 0;
                    m_run   = 1;
                    if (m_pend) begin
                        model_service();
                        m_pend = 0;
                    end
                end
                cmd_period = arg;
                cmd_start  = 1'b1;
                @(negedge clk);
                cmd_start  = 1'b0;
            end
            OP_IRQ: begin
                if (m_run) model_service();
                else       m_pend = 1;
                irq_fire = 1'b1;
                @(negedge clk);
                irq_fire = 1'b0;
            end
            OP_SNAP: begin
                if (m_run) begin
                    exp_q.push_back(bw(3'd4, 16'h0000));
                    exp_q.push_back(br(3'd4));
                    exp_q.push_back(br(3'd5));
                    m_snap = arg;
                    m_snapp++;
                end
                timer_count = arg;
                snap_req    = 1'b1;
                @(negedge clk);
                snap_req    = 1'b0;
            end
            default: begin
                if (m_run) begin
                    exp_q.push_back(bw(3'd1, 16'h0008));
                    m_run = 0;
                end
                cmd_stop = 1'b1;
                @(negedge clk);
                cmd_stop = 1'b0;
            end
        endcase
        repeat (8) @(negedge clk);
        compare_bus();
        check("tick_count", tick_count, m_ticks);
        check("running", {31'h0, running}, {31'h0, m_run});
        check("busy_settled", {31'h0, busy}, 32'h0);
        check("snap_value", snap_value, m_snap);
        check("tick_pulses", tick_seen, m_tickp);
        check("snap_pulses", snap_seen, m_snapp);
    endtask

    typedef struct {
        int          op;
        logic [31:0] arg;
        logic [31:0] e_ticks;
        logic        e_run;
        logic [31:0] e_snap;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{OP_START, 32'h0001_86A0, 32'd0, 1'b1, 32'h0};
        tbl[1] = '{OP_IRQ,   32'h0,         32'd1, 1'b1, 32'h0};
        tbl[2] = '{OP_IRQ,   32'h0,         32'd2, 1'b1, 32'h0};
        tbl[3] = '{OP_IRQ,   32'h0,         32'd3, 1'b1, 32'h0};
        tbl[4] = '{OP_SNAP,  32'h0001_2345, 32'd3, 1'b1, 32'h0001_2345};
        tbl[5] = '{OP_START, 32'hDEAD_BEEF, 32'd3, 1'b1, 32'h0001_2345};
        tbl[6] = '{OP_STOP,  32'h0,         32'd3, 1'b0, 32'h0001_2345};
        tbl[7] = '{OP_SNAP,  32'hFFFF_0000, 32'd3, 1'b0, 32'h0001_2345};
        tbl[8] = '{OP_STOP,  32'h0,         32'd3, 1'b0, 32'h0001_2345};
        tbl[9] = '{OP_IRQ,   32'h0,         32'd3, 1'b0, 32'h0001_2345};

        reset_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; snap_req = 1'b0;
        cmd_period = 32'h0; irq_fire = 1'b0; irq0 = 1'b0; timer_count = 32'h0;
        m_run = 0; m_pend = 0; m_ticks = 0; m_snap = 0;
        repeat (2) @(negedge clk);
        check("rst_cs", {31'h0, cs}, 32'h0);
        check("rst_write_n", {31'h0, wn}, 32'h1);
        check("rst_bus", {13'h0, addr, wdata}, 32'h0);
        check("rst_flags", {28'h0, busy, running, tick, snap_valid}, 32'h0);
        check("rst_tick_count", tick_count, 32'h0);
        check("rst_snap_value", snap_value, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].arg);
            check("tbl_ticks", tick_count, tbl[i].e_ticks);
            check("tbl_running", {31'h0, running}, {31'h0, tbl[i].e_run});
            check("tbl_snap", snap_value, tbl[i].e_snap);
        end
        // Entry 9 left an irq held by the timer; the next start services it.
        do_op(OP_START, 32'h0000_0400);
        check("pend_irq_ticks", tick_count, 32'd1);
        do_op(OP_STOP, 32'h0);

        // Start latency and exact write sequence.
        cmd_period = 32'h0001_86A0; cmd_start = 1'b1;
        @(negedge clk); cmd_start = 1'b0;
        check("start_c1", {cs, wn, 11'h0, addr, wdata}, {2'b10, 11'h0, 3'd2, 16'h86A0});
        check("start_c1_run", {31'h0, running}, 32'h0);
        @(negedge clk);
        check("start_c2", {cs, wn, 11'h0, addr, wdata}, {2'b10, 11'h0, 3'd3, 16'h0001});
        @(negedge clk);
        check("start_c3", {cs, wn, 11'h0, addr, wdata}, {2'b10, 11'h0, 3'd1, 16'h0007});
        check("start_c3_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("start_c4_run", {30'h0, running, cs}, {30'h0, 1'b1, 1'b0});

        // Snapshot latency.
        timer_count = 32'h0001_2345; snap_req = 1'b1;
        @(negedge clk); snap_req = 1'b0;
        check("snap_c1", {cs, wn, 11'h0, addr, wdata}, {2'b10, 11'h0, 3'd4, 16'h0});
        @(negedge clk);
        check("snap_c2", {cs, wn, 27'h0, addr}, {2'b11, 27'h0, 3'd4});
        @(negedge clk);
        check("snap_c3", {cs, wn, snap_valid, 26'h0, addr}, {3'b110, 26'h0, 3'd5});
        @(negedge clk);
        check("snap_c4_valid", {30'h0, snap_valid, cs}, {30'h0, 1'b1, 1'b0});
        check("snap_c4_value", snap_value, 32'h0001_2345);
        @(negedge clk);
        check("snap_c5", {30'h0, snap_valid, running}, {30'h0, 1'b0, 1'b1});
        check("snap_c5_value", snap_value, 32'h0001_2345);

        // irq and stop in the same RUN cycle: irq wins, stop dropped.
        irq_fire = 1'b1;
        @(negedge clk); irq_fire = 1'b0; cmd_stop = 1'b1;
        @(negedge clk); cmd_stop = 1'b0;
        check("irqstop_clr", {cs, wn, tick, 10'h0, addr, wdata}, {3'b101, 10'h0, 3'd0, 16'h0});
        @(negedge clk);
        check("irqstop_run", {29'h0, running, busy, tmr_irq}, {29'h0, 3'b100});
        check("irqstop_ticks", tick_count, 32'd1);
        cmd_stop = 1'b1;
        @(negedge clk); cmd_stop = 1'b0;
        check("stop_wr", {cs, wn, 11'h0, addr, wdata}, {2'b10, 11'h0, 3'd1, 16'h0008});
        @(negedge clk);
        check("stop_idle", {30'h0, running, busy}, 32'h0);
        m_tickp += 1; m_snapp += 1;
        flush();

        // Reset during WR_PH aborts immediately.
        cmd_period = 32'hCAFE_0042; cmd_start = 1'b1;
        @(negedge clk); cmd_start = 1'b0;
        @(negedge clk);
        check("rstmid_ph", {cs, wn, 11'h0, addr, wdata}, {2'b10, 11'h0, 3'd3, 16'hCAFE});
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_cs", {31'h0, cs}, 32'h0);
        check("rstmid_bus", {12'h0, wn, addr, wdata}, {12'h0, 1'b1, 3'd0, 16'h0});
        check("rstmid_flags", {28'h0, busy, running, tick, snap_valid}, 32'h0);
        check("rstmid_vals", tick_count | snap_value, 32'h0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rstmid_quiet", {30'h0, cs, busy}, 32'h0);
        cmd_period = 32'h0000_0100; cmd_start = 1'b1;
        @(negedge clk); cmd_start = 1'b0;
        check("restart_pl", {cs, wn, 11'h0, addr, wdata}, {2'b10, 11'h0, 3'd2, 16'h0100});

        // One-shot instance: single irq returns it to IDLE.
        repeat (3) @(negedge clk);
        check("os_running", {31'h0, running0}, 32'h1);
        irq0 = 1'b1;
        @(negedge clk);
        check("os_clr", {cs0, wn0, tick0, 10'h0, addr0, wdata0}, {3'b101, 10'h0, 3'd0, 16'h0});
        irq0 = 1'b0;
        @(negedge clk);
        check("os_idle", {30'h0, running0, busy0}, 32'h0);
        check("os_ticks", tick_count0, 32'd1);

        m_run = 1; m_pend = 0; m_ticks = 0; m_snap = 0;
        flush();

        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [31:0] arg;
            op  = int'($urandom_range(0, 3));
            arg = $urandom;
            do_op(op, arg);
        end

        check("idle_bus_values", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
